// File: rtl/reg_file_access_ctrl_if.sv
// reg_file_access_ctrl_if
//   Bundles every non-clock signal of the operand-fetch controller.
//   Signal groups:
//     - flush and the fetch request side (in_*);
//     - captured operands toward execute (out_*);
//     - writeback from the late pipeline (wb_*);
//     - register-file read/write port (rf_*);
//     - status (pending scoreboard, sticky proto_err).
//   Modports:
//     - slave: the controller itself.
//     - master: its environment (decode, execute, writeback and the register file).
interface reg_file_access_ctrl_if #(
  parameter int NUM_READ_PORTS = 3,
  parameter int SEL_WIDTH      = 4,
  parameter int DATA_WIDTH     = 32
);
  logic                                 flush;
  logic                                 in_valid;
  logic                                 in_ready;
  logic [NUM_READ_PORTS*SEL_WIDTH-1:0]  in_src_sel;
  logic [NUM_READ_PORTS-1:0]            in_src_en;
  logic [SEL_WIDTH-1:0]                 in_dst_sel;
  logic                                 in_dst_en;
  logic                                 out_valid;
  logic                                 out_ready;
  logic [NUM_READ_PORTS*DATA_WIDTH-1:0] out_src_data;
  logic [SEL_WIDTH-1:0]                 out_dst_sel;
  logic                                 out_dst_en;
  logic                                 wb_valid;
  logic [SEL_WIDTH-1:0]                 wb_sel;
  logic [DATA_WIDTH-1:0]                wb_data;
  logic [NUM_READ_PORTS*SEL_WIDTH-1:0]  rf_read_sel;
  logic [NUM_READ_PORTS*DATA_WIDTH-1:0] rf_read_data;
  logic [SEL_WIDTH-1:0]                 rf_write_sel;
  logic [DATA_WIDTH-1:0]                rf_write_data;
  logic                                 rf_write_en;
  logic [(2**SEL_WIDTH)-1:0]            pending;
  logic                                 proto_err;

  modport slave (
    input  flush, in_valid, in_src_sel, in_src_en, in_dst_sel, in_dst_en,
           out_ready, wb_valid, wb_sel, wb_data, rf_read_data,
    output in_ready, out_valid, out_src_data, out_dst_sel, out_dst_en,
           rf_read_sel, rf_write_sel, rf_write_data, rf_write_en, pending, proto_err
  );

  modport master (
    output flush, in_valid, in_src_sel, in_src_en, in_dst_sel, in_dst_en,
           out_ready, wb_valid, wb_sel, wb_data, rf_read_data,
    input  in_ready, out_valid, out_src_data, out_dst_sel, out_dst_en,
           rf_read_sel, rf_write_sel, rf_write_data, rf_write_en, pending, proto_err
  );
endinterface

// File: rtl/reg_file_access_ctrl.sv
// reg_file_access_ctrl
//   Operand-fetch controller between decode and execute.
//   - Accepts a fetch request and reads the register file combinationally.
//   - Registers the operands one cycle later, with same-cycle writeback bypass.
//   - Keeps a pending-write scoreboard that stalls RAW/WAW hazards.
//   Ports:
//     clk  - rising-edge clock
//     rst  - asynchronous active-high reset
//     bus  - reg_file_access_ctrl_if.slave; carries the request, operand,
//            writeback, register-file and status signals
module reg_file_access_ctrl #(
  parameter int NUM_READ_PORTS = 3,
  parameter int SEL_WIDTH      = 4,
  parameter int DATA_WIDTH     = 32
) (
  input logic                  clk,
  input logic                  rst,
  reg_file_access_ctrl_if.slave bus
);
  localparam int NUM_REGS = 2**SEL_WIDTH;
  localparam int OPS_W    = NUM_READ_PORTS*DATA_WIDTH;
  localparam logic [SEL_WIDTH-1:0] ZERO_SEL = {SEL_WIDTH{1'b0}};

  logic                 out_valid_q,    out_valid_d;
  logic [OPS_W-1:0]     out_src_data_q, out_src_data_d;
  logic [SEL_WIDTH-1:0] out_dst_sel_q,  out_dst_sel_d;
  logic                 out_dst_en_q,   out_dst_en_d;
  logic [NUM_REGS-1:0]  pending_q,      pending_d;
  logic                 proto_err_q,    proto_err_d;

  logic                 wb_live_s;
  logic [NUM_REGS-1:0]  clr_vec_s;
  logic [NUM_REGS-1:0]  set_vec_s;
  logic [NUM_REGS-1:0]  eff_pending_s;
  logic                 hazard_s;
  logic                 in_ready_s;
  logic                 accept_s;
  logic [OPS_W-1:0]     cap_data_s;

  // Writeback decode: register 0 is never written, so it never clears anything.
  always_comb begin
    wb_live_s = bus.wb_valid && (bus.wb_sel != ZERO_SEL);
    clr_vec_s = {NUM_REGS{1'b0}};
    if (wb_live_s) begin
      clr_vec_s[bus.wb_sel] = 1'b1;
    end else begin
      clr_vec_s = {NUM_REGS{1'b0}};
    end
    // A write landing this cycle already resolves its hazard.
    eff_pending_s = pending_q & ~clr_vec_s;
  end

  // Hazard detection and request acceptance; in_ready ignores in_valid.
  always_comb begin
    hazard_s = 1'b0;
    for (int i = 0; i < NUM_READ_PORTS; i++) begin
      if (bus.in_src_en[i] && eff_pending_s[bus.in_src_sel[i*SEL_WIDTH +: SEL_WIDTH]]) begin
        hazard_s = 1'b1;
      end else begin
        hazard_s = hazard_s;
      end
    end
    if (bus.in_dst_en && eff_pending_s[bus.in_dst_sel]) begin
      hazard_s = 1'b1;
    end else begin
      hazard_s = hazard_s;
    end
    in_ready_s = !bus.flush && !hazard_s && (!out_valid_q || bus.out_ready);
    accept_s   = bus.in_valid && in_ready_s;
  end

  // Operand selection: zero register / unused source, then bypass, then register file.
  always_comb begin
    cap_data_s = {OPS_W{1'b0}};
    for (int i = 0; i < NUM_READ_PORTS; i++) begin
      if (!bus.in_src_en[i] || (bus.in_src_sel[i*SEL_WIDTH +: SEL_WIDTH] == ZERO_SEL)) begin
        cap_data_s[i*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{1'b0}};
      end else if (bus.wb_valid && (bus.wb_sel == bus.in_src_sel[i*SEL_WIDTH +: SEL_WIDTH])) begin
        cap_data_s[i*DATA_WIDTH +: DATA_WIDTH] = bus.wb_data;
      end else begin
        cap_data_s[i*DATA_WIDTH +: DATA_WIDTH] = bus.rf_read_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Next-state computation for the output register, scoreboard and error flag.
  always_comb begin
    set_vec_s = {NUM_REGS{1'b0}};
    if (accept_s && bus.in_dst_en && (bus.in_dst_sel != ZERO_SEL)) begin
      set_vec_s[bus.in_dst_sel] = 1'b1;
    end else begin
      set_vec_s = {NUM_REGS{1'b0}};
    end

    out_valid_d    = out_valid_q;
    out_src_data_d = out_src_data_q;
    out_dst_sel_d  = out_dst_sel_q;
    out_dst_en_d   = out_dst_en_q;
    if (bus.flush) begin
      out_valid_d = 1'b0;
    end else if (accept_s) begin
      out_valid_d    = 1'b1;
      out_src_data_d = cap_data_s;
      out_dst_sel_d  = bus.in_dst_sel;
      out_dst_en_d   = bus.in_dst_en;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    // OR-ing set after the clear lets a new claim win over a same-cycle retire.
    if (bus.flush) begin
      pending_d = {NUM_REGS{1'b0}};
    end else begin
      pending_d = eff_pending_s | set_vec_s;
    end

    // Sticky: a writeback nobody claimed is a protocol error, flush or not.
    proto_err_d = proto_err_q | (wb_live_s && !pending_q[bus.wb_sel]);
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q    <= 1'b0;
      out_src_data_q <= {OPS_W{1'b0}};
      out_dst_sel_q  <= ZERO_SEL;
      out_dst_en_q   <= 1'b0;
      pending_q      <= {NUM_REGS{1'b0}};
      proto_err_q    <= 1'b0;
    end else begin
      out_valid_q    <= out_valid_d;
      out_src_data_q <= out_src_data_d;
      out_dst_sel_q  <= out_dst_sel_d;
      out_dst_en_q   <= out_dst_en_d;
      pending_q      <= pending_d;
      proto_err_q    <= proto_err_d;
    end
  end

  assign bus.in_ready      = in_ready_s;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_src_data  = out_src_data_q;
  assign bus.out_dst_sel   = out_dst_sel_q;
  assign bus.out_dst_en    = out_dst_en_q;
  assign bus.pending       = pending_q;
  assign bus.proto_err     = proto_err_q;
  assign bus.rf_read_sel   = bus.in_src_sel;
  assign bus.rf_write_sel  = bus.wb_sel;
  assign bus.rf_write_data = bus.wb_data;
  assign bus.rf_write_en   = wb_live_s;
endmodule

// File: tb/tb_reg_file_access_ctrl.sv
module tb_reg_file_access_ctrl;
  localparam int NRP = 3;
  localparam int SW  = 4;
  localparam int DW  = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_file_access_ctrl_if #(.NUM_READ_PORTS(NRP), .SEL_WIDTH(SW), .DATA_WIDTH(DW)) bus ();

  reg_file_access_ctrl #(.NUM_READ_PORTS(NRP), .SEL_WIDTH(SW), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [NRP*DW-1:0] data;
    logic [SW-1:0]     dst;
    logic              dst_en;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
  endtask

  // Monitor: every output handshake pops and compares the oldest expected item.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_output: got data 0x%0h with empty scoreboard", bus.out_src_data);
        end else begin
          e = exp_q.pop_front();
          check("out_src_data", 128'(bus.out_src_data), 128'(e.data));
          check("out_dst_sel",  128'(bus.out_dst_sel),  128'(e.dst));
          check("out_dst_en",   128'(bus.out_dst_en),   128'(e.dst_en));
        end
      end
    end
  end

  // Drive one request for a cycle; expected operands are queued if it should be accepted.
  task automatic issue(input logic [SW-1:0] s0, input logic [SW-1:0] s1, input logic [SW-1:0] s2,
                       input logic [NRP-1:0] en, input logic [SW-1:0] dst, input logic dst_en,
                       input logic [DW-1:0] r0, input logic [DW-1:0] r1, input logic [DW-1:0] r2,
                       input logic exp_rdy,
                       input logic [DW-1:0] e0, input logic [DW-1:0] e1, input logic [DW-1:0] e2);
    exp_t e;
    bus.in_valid     = 1'b1;
    bus.in_src_sel   = {s2, s1, s0};
    bus.in_src_en    = en;
    bus.in_dst_sel   = dst;
    bus.in_dst_en    = dst_en;
    bus.rf_read_data = {r2, r1, r0};
    @(negedge clk);
    check("in_ready", 128'(bus.in_ready), 128'(exp_rdy));
    check("rf_read_sel", 128'(bus.rf_read_sel), 128'({s2, s1, s0}));
    if (exp_rdy) begin
      e.data   = {e2, e1, e0};
      e.dst    = dst;
      e.dst_en = dst_en;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wb_cycle(input logic [SW-1:0] sel, input logic [DW-1:0] data);
    bus.wb_valid = 1'b1;
    bus.wb_sel   = sel;
    bus.wb_data  = data;
    @(posedge clk);
    #1;
    bus.wb_valid = 1'b0;
  endtask

  initial begin
    rst              = 1'b1;
    bus.flush        = 1'b0;
    bus.in_valid     = 1'b0;
    bus.in_src_sel   = '0;
    bus.in_src_en    = '0;
    bus.in_dst_sel   = '0;
    bus.in_dst_en    = 1'b0;
    bus.out_ready    = 1'b1;
    bus.wb_valid     = 1'b0;
    bus.wb_sel       = '0;
    bus.wb_data      = '0;
    bus.rf_read_data = '0;
    #1;
    check("rst_out_valid", 128'(bus.out_valid), 128'(0));
    check("rst_out_data",  128'(bus.out_src_data), 128'(0));
    check("rst_pending",   128'(bus.pending), 128'(0));
    check("rst_proto_err", 128'(bus.proto_err), 128'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic fetch: source 0 reads as zero despite rf data 0xC.
    issue(4'd1, 4'd2, 4'd0, 3'b111, 4'd5, 1'b1, 32'hA, 32'hB, 32'hC, 1'b1, 32'hA, 32'hB, 32'h0);
    check("t1_out_valid", 128'(bus.out_valid), 128'(1));
    check("t1_pending",   128'(bus.pending), 128'(16'h0020));

    // RAW on r5 stalls, then resolves with bypass of same-cycle writeback.
    issue(4'd5, 4'd0, 4'd0, 3'b001, 4'd0, 1'b0, 32'h99, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0);
    bus.wb_valid = 1'b1; bus.wb_sel = 4'd5; bus.wb_data = 32'h1234;
    #1;
    check("t2_rf_write_en",   128'(bus.rf_write_en), 128'(1));
    check("t2_rf_write_sel",  128'(bus.rf_write_sel), 128'(5));
    check("t2_rf_write_data", 128'(bus.rf_write_data), 128'(32'h1234));
    issue(4'd5, 4'd0, 4'd0, 3'b001, 4'd0, 1'b0, 32'h99, 32'h0, 32'h0, 1'b1, 32'h1234, 32'h0, 32'h0);
    bus.wb_valid = 1'b0;
    check("t2_pending",   128'(bus.pending), 128'(0));
    check("t2_proto_err", 128'(bus.proto_err), 128'(0));

    // WAW on r3: stall, then accept with same-cycle retire; set wins.
    issue(4'd0, 4'd0, 4'd0, 3'b000, 4'd3, 1'b1, 32'h0, 32'h0, 32'h0, 1'b1, 32'h0, 32'h0, 32'h0);
    check("t3_pending_set", 128'(bus.pending), 128'(16'h0008));
    issue(4'd0, 4'd0, 4'd0, 3'b000, 4'd3, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0);
    bus.wb_valid = 1'b1; bus.wb_sel = 4'd3; bus.wb_data = 32'h55;
    issue(4'd0, 4'd0, 4'd0, 3'b000, 4'd3, 1'b1, 32'h0, 32'h0, 32'h0, 1'b1, 32'h0, 32'h0, 32'h0);
    bus.wb_valid = 1'b0;
    check("t3_pending_kept", 128'(bus.pending), 128'(16'h0008));
    wb_cycle(4'd3, 32'h66);
    check("t3_pending_clr", 128'(bus.pending), 128'(0));

    // Back-pressure: held output, no accept, then release.
    issue(4'd1, 4'd2, 4'd4, 3'b111, 4'd6, 1'b1, 32'h11, 32'h22, 32'h44, 1'b1, 32'h11, 32'h22, 32'h44);
    bus.out_ready    = 1'b0;
    bus.in_valid     = 1'b1;
    bus.in_src_sel   = {4'd10, 4'd9, 4'd8};
    bus.in_src_en    = 3'b111;
    bus.in_dst_sel   = 4'd0;
    bus.in_dst_en    = 1'b0;
    bus.rf_read_data = {32'hAA, 32'h99, 32'h88};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t4_bp_in_ready",  128'(bus.in_ready), 128'(0));
      check("t4_bp_out_valid", 128'(bus.out_valid), 128'(1));
      check("t4_bp_data",      128'(bus.out_src_data), 128'({32'h44, 32'h22, 32'h11}));
      check("t4_bp_dst",       128'(bus.out_dst_sel), 128'(6));
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    issue(4'd8, 4'd9, 4'd10, 3'b111, 4'd0, 1'b0, 32'h88, 32'h99, 32'hAA, 1'b1, 32'h88, 32'h99, 32'hAA);
    check("t4_new_data", 128'(bus.out_src_data), 128'({32'hAA, 32'h99, 32'h88}));
    wb_cycle(4'd6, 32'h6);
    check("t4_pending", 128'(bus.pending), 128'(0));

    // Writes to r0 are masked and raise no error; unclaimed r7 raises sticky error.
    bus.wb_valid = 1'b1; bus.wb_sel = 4'd0; bus.wb_data = 32'hDEAD;
    #1;
    check("t5_r0_write_en", 128'(bus.rf_write_en), 128'(0));
    @(posedge clk);
    #1;
    bus.wb_valid = 1'b0;
    check("t5_r0_no_err", 128'(bus.proto_err), 128'(0));
    wb_cycle(4'd7, 32'h77);
    check("t5_err_set", 128'(bus.proto_err), 128'(1));
    repeat (2) @(posedge clk);
    #1;
    check("t5_err_sticky", 128'(bus.proto_err), 128'(1));

    // Flush with pending=0x00F0 and a held output.
    issue(4'd0, 4'd0, 4'd0, 3'b000, 4'd4, 1'b1, 32'h0, 32'h0, 32'h0, 1'b1, 32'h0, 32'h0, 32'h0);
    issue(4'd0, 4'd0, 4'd0, 3'b000, 4'd5, 1'b1, 32'h0, 32'h0, 32'h0, 1'b1, 32'h0, 32'h0, 32'h0);
    issue(4'd0, 4'd0, 4'd0, 3'b000, 4'd6, 1'b1, 32'h0, 32'h0, 32'h0, 1'b1, 32'h0, 32'h0, 32'h0);
    issue(4'd0, 4'd0, 4'd0, 3'b000, 4'd7, 1'b1, 32'h0, 32'h0, 32'h0, 1'b1, 32'h0, 32'h0, 32'h0);
    check("t6_pending_f0", 128'(bus.pending), 128'(16'h00F0));
    bus.out_ready  = 1'b0;
    bus.flush      = 1'b1;
    bus.in_valid   = 1'b1;
    bus.in_src_en  = 3'b000;
    bus.in_dst_en  = 1'b0;
    bus.wb_valid   = 1'b1; bus.wb_sel = 4'd9; bus.wb_data = 32'h9;
    @(negedge clk);
    check("t6_flush_in_ready", 128'(bus.in_ready), 128'(0));
    check("t6_flush_wr_en",    128'(bus.rf_write_en), 128'(1));
    @(posedge clk);
    #1;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.wb_valid = 1'b0; bus.out_ready = 1'b1;
    check("t6_out_valid", 128'(bus.out_valid), 128'(0));
    check("t6_pending",   128'(bus.pending), 128'(0));
    if (exp_q.size() > 0) void'(exp_q.pop_front());

    // Reset pulse mid-stream clears all state immediately.
    issue(4'd1, 4'd0, 4'd0, 3'b001, 4'd9, 1'b1, 32'h5A, 32'h0, 32'h0, 1'b1, 32'h5A, 32'h0, 32'h0);
    bus.out_ready = 1'b0;
    #2;
    rst = 1'b1;
    bus.wb_valid = 1'b1; bus.wb_sel = 4'd2; bus.wb_data = 32'h2;
    #1;
    check("t7_out_valid", 128'(bus.out_valid), 128'(0));
    check("t7_out_data",  128'(bus.out_src_data), 128'(0));
    check("t7_out_dst",   128'({bus.out_dst_sel, bus.out_dst_en}), 128'(0));
    check("t7_pending",   128'(bus.pending), 128'(0));
    check("t7_proto_err", 128'(bus.proto_err), 128'(0));
    check("t7_wr_en_rst", 128'(bus.rf_write_en), 128'(1));
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.wb_valid  = 1'b0;
    bus.out_ready = 1'b1;

    // Recovery after reset.
    issue(4'd3, 4'd0, 4'd0, 3'b001, 4'd0, 1'b0, 32'h33, 32'h0, 32'h0, 1'b1, 32'h33, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    check("queue_drained", 128'(exp_q.size()), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
